// File: rtl/el2_pkg.sv
// el2_pkg: shared types and constants for the IFU/decode instruction buffer.
//   el2_ibuf_entry_t : one buffered instruction {instr, pc[31:1], pc4, icaf, dbecc}
//   IBUF_DEPTH       : default number of instruction buffer entries
package el2_pkg;

  localparam int unsigned IBUF_DEPTH = 4;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:1] pc;
    logic        pc4;
    logic        icaf;
    logic        dbecc;
  } el2_ibuf_entry_t;

endpackage

// File: rtl/el2_ifu_dec_ibuf.sv
// el2_ifu_dec_ibuf: FIFO instruction buffer between the IFU aligner and decode.
//
// Optional feature macro: RV_IBUF_BYPASS_EN
//   When defined, a write into an empty buffer is presented on the ib_* outputs in
//   the same cycle and, if decode takes it, it is never stored.
//
// Ports:
//   clk, rst_l       core clock, asynchronous active-low reset
//   exu_flush_final  discards all buffered entries on the next edge
//   ifu_i0_*         aligner instruction (valid, instr, pc[31:1], flags {dbecc,icaf,pc4})
//   ibuf_full        back-pressure; input not accepted while high
//   dec_i0_decode_d  decode consumes the head entry
//   ib_i0_*          head entry toward decode (valid, instr, pc, flags)
//   ib_count         number of occupied entries
module el2_ifu_dec_ibuf
  import el2_pkg::*;
#(
  parameter int unsigned DEPTH = IBUF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_l,
  input  logic                     exu_flush_final,
  input  logic                     ifu_i0_valid,
  input  logic [31:0]              ifu_i0_instr,
  input  logic [31:1]              ifu_i0_pc,
  input  logic [2:0]               ifu_i0_flags,
  output logic                     ibuf_full,
  input  logic                     dec_i0_decode_d,
  output logic                     ib_i0_valid,
  output logic [31:0]              ib_i0_instr,
  output logic [31:1]              ib_i0_pc,
  output logic [2:0]               ib_i0_flags,
  output logic [$clog2(DEPTH):0]   ib_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  el2_ibuf_entry_t mem_q [DEPTH];

  el2_ibuf_entry_t in_entry;
  el2_ibuf_entry_t head_entry;
  logic            empty;
  logic            wr;
  logic            bypass;
  logic            head_vld;
  logic            push;
  logic            pop;

  always_comb begin
    in_entry       = '0;
    in_entry.instr = ifu_i0_instr;
    in_entry.pc    = ifu_i0_pc;
    in_entry.dbecc = ifu_i0_flags[2];
    in_entry.icaf  = ifu_i0_flags[1];
    in_entry.pc4   = ifu_i0_flags[0];
  end

  // Full is derived only from registered occupancy, so decode cannot ripple into it.
  assign ibuf_full = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign wr        = ifu_i0_valid & ~ibuf_full & ~exu_flush_final;
  assign head_vld  = ~empty & ~exu_flush_final;

`ifdef RV_IBUF_BYPASS_EN
  assign bypass = empty & wr;
`else
  assign bypass = 1'b0;
`endif

  assign ib_i0_valid = head_vld | bypass;
  // A bypassed instruction taken by decode in the same cycle is never stored.
  assign push        = wr & ~(bypass & dec_i0_decode_d);
  assign pop         = head_vld & dec_i0_decode_d;

  always_comb begin
    head_entry = '0;
    if (bypass) begin
      head_entry = in_entry;
    end else if (!empty) begin
      head_entry = mem_q[rd_ptr_q];
    end
  end

  assign ib_i0_instr = head_entry.instr;
  assign ib_i0_pc    = head_entry.pc;
  assign ib_i0_flags = {head_entry.dbecc, head_entry.icaf, head_entry.pc4};
  assign ib_count    = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (exu_flush_final) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage carries no reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_entry;
  end

endmodule

// File: tb/tb_el2_ifu_dec_ibuf.sv
// Testbench for el2_ifu_dec_ibuf: directed vector table, hand-written corner
// sequences (flush, bypass/latency, async reset) and randomized traffic checked
// against a queue-based reference model.
module tb_el2_ifu_dec_ibuf;
  import el2_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;
`ifdef RV_IBUF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_l;
  logic          exu_flush_final;
  logic          ifu_i0_valid;
  logic [31:0]   ifu_i0_instr;
  logic [31:1]   ifu_i0_pc;
  logic [2:0]    ifu_i0_flags;
  logic          ibuf_full;
  logic          dec_i0_decode_d;
  logic          ib_i0_valid;
  logic [31:0]   ib_i0_instr;
  logic [31:1]   ib_i0_pc;
  logic [2:0]    ib_i0_flags;
  logic [CW-1:0] ib_count;

  el2_ifu_dec_ibuf #(.DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst_l           (rst_l),
    .exu_flush_final (exu_flush_final),
    .ifu_i0_valid    (ifu_i0_valid),
    .ifu_i0_instr    (ifu_i0_instr),
    .ifu_i0_pc       (ifu_i0_pc),
    .ifu_i0_flags    (ifu_i0_flags),
    .ibuf_full       (ibuf_full),
    .dec_i0_decode_d (dec_i0_decode_d),
    .ib_i0_valid     (ib_i0_valid),
    .ib_i0_instr     (ib_i0_instr),
    .ib_i0_pc        (ib_i0_pc),
    .ib_i0_flags     (ib_i0_flags),
    .ib_count        (ib_count)
  );

  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;
  int pops   = 0;

  // Reference model: the buffer contents, oldest first.
  el2_ibuf_entry_t model_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic vld, input logic [31:0] instr, input logic [31:0] pc_byte,
                       input logic [2:0] flags, input logic dec, input logic flush);
    ifu_i0_valid    = vld;
    ifu_i0_instr    = instr;
    ifu_i0_pc       = pc_byte[31:1];
    ifu_i0_flags    = flags;
    dec_i0_decode_d = dec;
    exu_flush_final = flush;
  endtask

  function automatic el2_ibuf_entry_t incoming();
    el2_ibuf_entry_t e;
    e.instr = ifu_i0_instr;
    e.pc    = ifu_i0_pc;
    e.dbecc = ifu_i0_flags[2];
    e.icaf  = ifu_i0_flags[1];
    e.pc4   = ifu_i0_flags[0];
    return e;
  endfunction

  function automatic bit m_accept();
    return ifu_i0_valid && (model_q.size() < DEPTH) && !exu_flush_final;
  endfunction

  function automatic bit m_bypass();
    return BYP && (model_q.size() == 0) && m_accept();
  endfunction

  function automatic bit m_valid();
    return ((model_q.size() != 0) && !exu_flush_final) || m_bypass();
  endfunction

  // Compare DUT outputs with the model under the currently driven inputs.
  task automatic check_model();
    el2_ibuf_entry_t h;
    chk("m_valid", 64'(ib_i0_valid), 64'(m_valid()));
    chk("m_full",  64'(ibuf_full),   64'(model_q.size() == DEPTH));
    chk("m_count", 64'(ib_count),    64'(model_q.size()));
    if (m_valid()) begin
      h = m_bypass() ? incoming() : model_q[0];
      chk("m_instr", 64'(ib_i0_instr), 64'(h.instr));
      chk("m_pc",    64'(ib_i0_pc),    64'(h.pc));
      chk("m_flags", 64'(ib_i0_flags), 64'({h.dbecc, h.icaf, h.pc4}));
    end
  endtask

  // Advance one clock and apply the same edge to the model.
  task automatic tick();
    bit acc, byp, take;
    el2_ibuf_entry_t e;
    acc  = m_accept();
    byp  = m_bypass();
    take = m_valid() && dec_i0_decode_d;
    e    = incoming();
    @(posedge clk);
    if (exu_flush_final) begin
      model_q.delete();
    end else begin
      if (take) pops++;
      if (take && !byp) void'(model_q.pop_front());
      if (acc && !(byp && dec_i0_decode_d)) model_q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic step(input logic vld, input logic [31:0] instr, input logic [31:0] pc_byte,
                      input logic dec, input logic flush);
    drive(vld, instr, pc_byte, 3'(instr[2:0]), dec, flush);
    #1;
    check_model();
    tick();
  endtask

  typedef struct {
    logic          vld;
    logic [31:0]   pc;
    logic          dec;
    logic          exp_valid;
    logic          exp_full;
    logic [CW-1:0] exp_count;
    logic [31:0]   exp_pc;
  } vec_t;

  vec_t vecs [10];

  initial begin
    // Four writes, a rejected fifth, full with rd+valid, then in-order drain.
    vecs[0] = '{1'b1, 32'h100, 1'b0, BYP,  1'b0, 3'd0, 32'h100};
    vecs[1] = '{1'b1, 32'h104, 1'b0, 1'b1, 1'b0, 3'd1, 32'h100};
    vecs[2] = '{1'b1, 32'h108, 1'b0, 1'b1, 1'b0, 3'd2, 32'h100};
    vecs[3] = '{1'b1, 32'h10C, 1'b0, 1'b1, 1'b0, 3'd3, 32'h100};
    vecs[4] = '{1'b1, 32'h110, 1'b0, 1'b1, 1'b1, 3'd4, 32'h100};
    vecs[5] = '{1'b1, 32'h110, 1'b1, 1'b1, 1'b1, 3'd4, 32'h100};
    vecs[6] = '{1'b0, 32'h0,   1'b1, 1'b1, 1'b0, 3'd3, 32'h104};
    vecs[7] = '{1'b0, 32'h0,   1'b1, 1'b1, 1'b0, 3'd2, 32'h108};
    vecs[8] = '{1'b0, 32'h0,   1'b1, 1'b1, 1'b0, 3'd1, 32'h10C};
    vecs[9] = '{1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 3'd0, 32'h0};

    rst_l = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 3'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", 64'(ib_i0_valid), 64'd0);
    chk("rst_full",  64'(ibuf_full),   64'd0);
    chk("rst_count", 64'(ib_count),    64'd0);
    @(negedge clk);
    rst_l = 1'b1;

    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].vld, 32'hA000_0000 | vecs[i].pc, vecs[i].pc, 3'(i), vecs[i].dec, 1'b0);
      #1;
      check_model();
      chk($sformatf("vec%0d_valid", i), 64'(ib_i0_valid), 64'(vecs[i].exp_valid));
      chk($sformatf("vec%0d_full", i),  64'(ibuf_full),   64'(vecs[i].exp_full));
      chk($sformatf("vec%0d_count", i), 64'(ib_count),    64'(vecs[i].exp_count));
      if (vecs[i].exp_valid)
        chk($sformatf("vec%0d_pc", i), 64'({ib_i0_pc, 1'b0}), 64'(vecs[i].exp_pc));
      tick();
    end

    // Flush with count 2 and a simultaneous write: nothing survives.
    step(1'b1, 32'h1111, 32'h200, 1'b0, 1'b0);
    step(1'b1, 32'h2222, 32'h204, 1'b0, 1'b0);
    drive(1'b1, 32'h3333, 32'h208, 3'b0, 1'b1, 1'b1);
    #1;
    chk("flush_cnt_before", 64'(ib_count),    64'd2);
    chk("flush_valid",      64'(ib_i0_valid), 64'd0);
    check_model();
    tick();
    drive(1'b0, 32'h0, 32'h0, 3'b0, 1'b0, 1'b0);
    #1;
    chk("flush_count_after", 64'(ib_count),    64'd0);
    chk("flush_valid_after", 64'(ib_i0_valid), 64'd0);
    tick();
    step(1'b1, 32'h4444, 32'h20C, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 3'b0, 1'b1, 1'b0);
    #1;
    chk("post_flush_head", 64'(ib_i0_instr), 64'h4444);
    check_model();
    tick();

    // Write into empty with decode high: bypass vs one-cycle latency.
    drive(1'b1, 32'h0000_0013, 32'h300, 3'b0, 1'b1, 1'b0);
    #1;
    chk("lat_valid_same", 64'(ib_i0_valid), 64'(BYP));
    if (BYP) chk("byp_instr", 64'(ib_i0_instr), 64'h13);
    check_model();
    tick();
    drive(1'b0, 32'h0, 32'h0, 3'b0, 1'b0, 1'b0);
    #1;
    chk("lat_valid_next", 64'(ib_i0_valid), 64'(!BYP));
    chk("lat_count_next", 64'(ib_count),    64'(!BYP));
    if (!BYP) chk("lat_instr", 64'(ib_i0_instr), 64'h13);
    tick();
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Asynchronous reset mid-operation with three entries.
    for (int i = 0; i < 3; i++) step(1'b1, 32'h5000 + 32'(i), 32'h400 + 32'(4 * i), 1'b0, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 3'b0, 1'b0, 1'b0);
    #1;
    chk("arst_pre_count", 64'(ib_count), 64'd3);
    #1;
    rst_l = 1'b0;
    #1;
    chk("arst_valid", 64'(ib_i0_valid), 64'd0);
    chk("arst_full",  64'(ibuf_full),   64'd0);
    chk("arst_count", 64'(ib_count),    64'd0);
    chk("arst_instr", 64'(ib_i0_instr), 64'd0);
    chk("arst_pc",    64'(ib_i0_pc),    64'd0);
    chk("arst_flags", 64'(ib_i0_flags), 64'd0);
    model_q.delete();
    @(negedge clk);
    rst_l = 1'b1;
    step(1'b1, 32'h6666, 32'h500, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 3'b0, 1'b1, 1'b0);
    #1;
    chk("arst_first_head", 64'(ib_i0_instr), 64'h6666);
    check_model();
    tick();

    // Randomized traffic across many pointer wraps.
    pops = 0;
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), $urandom, {$urandom_range(0, 32'hFFFF), 1'b0},
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 40) == 0));
    end
    chk("rand_enough_reads", 64'(pops > 3 * DEPTH), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
